mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
- Next-generation multicycle control unit for the parametrised MIPS core; drives the same datapath control signals.
- Instruction fetch is generalised to 32/WIDTH memory chunks.
- Adds a memory ready handshake (variable wait states), BNE and ADDI, and a per-instruction completion pulse.
- Sits between the datapath's op/funct/zero outputs and its control inputs; Moore FSM plus combinational output decode.

Parameters:
- WIDTH, 8, datapath/memory word width in bits; legal values are 8, 16 and 32. Localparam CHUNKS = 32/WIDTH (4, 2 or 1).

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU result == 0
- memready  in  1  memory completes the current read/write this cycle
- pcen  out  1  PC write enable
- pcsrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- memread  out  1  memory read request
- memwrite  out  1  memory write request
- irwrite  out  CHUNKS  one-hot IR chunk write enable; bit k loads instr[WIDTH*k +: WIDTH]
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = MDR to register file
- regwrite  out  1  register file write enable
- alusrca  out  1  0 = PC, 1 = regA
- alusrcb  out  2  00 regB, 01 constant 1, 10 imm, 11 imm for branch target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- instr_done  out  1  one-cycle pulse in an instruction's final state
- trap  out  1  illegal-instruction flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset: FSM goes to FETCH with chunk counter k = 0. While reset = 1, every output is forced 0. Reset mid-wait abandons the access; there is no partial IR or PC update after release.
- Outputs not listed for a state are 0.
- FETCH[k]:
  - iord=0, memread=1, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - When memready=1: irwrite[k]=1 and pcen=1 (PC+1) in the same cycle. k increments; after k = CHUNKS-1 go to DECODE.
  - When memready=0: stay in the state with no strobes asserted.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut). Dispatch on op:
  - 100011 LW and 101011 SW -> MEMADR
  - 000000 R-type -> RTYPEEX
  - 000100 BEQ -> BEQEX
  - 000101 BNE -> BNEEX
  - 001000 ADDI -> ADDIEX
  - 000010 J -> JEX
  - any other op -> ILLEGAL
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010. Go to LWRD (LW) or SWWR (SW).
- LWRD: iord=1, memread=1. Hold until memready=1, then go to LWWR.
- LWWR: regwrite=1, memtoreg=1, regdst=0, instr_done=1. Go to FETCH k=0.
- SWWR: iord=1, memwrite=1. Hold until memready=1. On that cycle instr_done=1 and go to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00. alucontrol is decoded from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - other funct -> ILLEGAL path
- RTYPEWR: regdst=1, regwrite=1, alucontrol held from RTYPEEX, instr_done=1.
- BEQEX / BNEEX: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01. pcen=zero (BEQ) or pcen=~zero (BNE). instr_done=1. Go to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, alucontrol=010. Go to ADDIWR.
- ADDIWR: regdst=0, memtoreg=0, regwrite=1, instr_done=1.
- JEX: pcsrc=10, pcen=1, instr_done=1.
- Latency with memready tied 1, CHUNKS=4:
  - R-type 7 cycles; LW 8; SW 7; BEQ/BNE/J 6; ADDI 7.
  - Each memready=0 cycle adds 1 cycle.
- memread and memwrite are never both 1. memread/memwrite stay asserted, with iord stable, until the memready cycle.

Optional Feature:
- Macro: MIPS_MC_ILLEGAL_TRAP_EN.
- Defined:
  - ILLEGAL is a sticky TRAP state: trap=1, all other outputs 0, no PC/register/memory writes.
  - Only reset exits TRAP.
- Undefined:
  - ILLEGAL lasts one cycle: instr_done=1, no writes, then FETCH k=0. The instruction acts as a no-op.
  - trap is tied 0.

Test Plan:
- WIDTH=8, memready=1, add (op 000000, funct 100000) -> four FETCH cycles with irwrite 0001, 0010, 0100, 1000 and pcen=1 each; then DECODE; RTYPEEX alucontrol=010; RTYPEWR regdst=1, regwrite=1, instr_done=1 at cycle 7.
- WIDTH=16, LW with memready low for 2 cycles during LWRD -> irwrite 01 then 10; LWRD held 3 cycles with iord=1, memread=1; LWWR memtoreg=1, regwrite=1; total 8 cycles.
- BEQ with zero=1 then BNE with zero=1 -> BEQEX pcen=1, pcsrc=01; BNEEX pcen=0; both pulse instr_done.
- WIDTH=32, SW with memready=0 for 3 cycles -> irwrite 1 for the single fetch; SWWR memwrite=1 for 4 cycles; memread=0 throughout SWWR; instr_done on the 4th cycle.
- reset asserted during LWRD wait -> all outputs 0 that cycle; next cycle FETCH k=0 with irwrite[0] on memready; no regwrite ever asserted.
- op 111111 -> with MIPS_MC_ILLEGAL_TRAP_EN, trap=1 indefinitely and pcen/regwrite/memwrite=0 until reset; without it, one cycle with instr_done=1, then FETCH.

Source files
------------

// File: rtl/mips_mc_controller.sv
//------------------------------------------------------------------------------
// mips_mc_controller
//
// Multicycle control unit for the parametrised MIPS core. It is a Moore FSM
// with a combinational output decode. Instruction fetch is split into
// CHUNKS = 32/WIDTH memory reads, and every memory access waits on memready.
//
// Parameters:
//   WIDTH       datapath/memory word width (8, 16 or 32)
//
// Optional feature (compile-time macro MIPS_MC_ILLEGAL_TRAP_EN):
//   defined   - an illegal op/funct parks the FSM in a sticky TRAP state
//               (trap=1, no writes) that only reset leaves
//   undefined - an illegal instruction is a one-cycle no-op; trap is tied 0
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   op, funct, zero      instruction fields and ALU zero flag from datapath
//   memready             memory completes the current access this cycle
//   pcen, pcsrc          PC write enable and PC source select
//   iord                 memory address select (0 = PC, 1 = ALUOut)
//   memread, memwrite    memory request strobes
//   irwrite              one-hot IR chunk write enable
//   regdst, memtoreg,
//   regwrite             register file controls
//   alusrca, alusrcb,
//   alucontrol           ALU operand selects and operation
//   instr_done           one-cycle pulse in an instruction's final state
//   trap                 illegal-instruction flag
//------------------------------------------------------------------------------
module mips_mc_controller #(
    parameter int WIDTH = 8,
    localparam int CHUNKS = 32 / WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              memready,
    output logic              pcen,
    output logic [1:0]        pcsrc,
    output logic              iord,
    output logic              memread,
    output logic              memwrite,
    output logic [CHUNKS-1:0] irwrite,
    output logic              regdst,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [2:0]        alucontrol,
    output logic              instr_done,
    output logic              trap
);

    // FSM state encoding
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_LWRD    = 4'd3;
    localparam logic [3:0] S_LWWR    = 4'd4;
    localparam logic [3:0] S_SWWR    = 4'd5;
    localparam logic [3:0] S_RTYPEEX = 4'd6;
    localparam logic [3:0] S_RTYPEWR = 4'd7;
    localparam logic [3:0] S_BEQEX   = 4'd8;
    localparam logic [3:0] S_BNEEX   = 4'd9;
    localparam logic [3:0] S_ADDIEX  = 4'd10;
    localparam logic [3:0] S_ADDIWR  = 4'd11;
    localparam logic [3:0] S_JEX     = 4'd12;
    localparam logic [3:0] S_ILLEGAL = 4'd13;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Chunk counter is 2 bits wide for every legal WIDTH (at most 4 chunks)
    localparam logic [1:0] LAST_K = 2'(CHUNKS - 1);

    logic [3:0] state_q, state_d;
    logic [1:0] k_q, k_d;
    logic [2:0] rt_alu_q, rt_alu_d;   // R-type ALU op captured in RTYPEEX

    logic       funct_ok;
    logic [2:0] funct_alu;

    // R-type function decode
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Next-state logic
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        rt_alu_d = rt_alu_q;
        case (state_q)
            S_FETCH: begin
                if (memready) begin
                    if (k_q == LAST_K) begin
                        state_d = S_DECODE;
                        k_d     = 2'd0;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_BNE:       state_d = S_BNEEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            // Only LW and SW reach MEMADR, so SW vs. not-SW is sufficient
            S_MEMADR: state_d = (op == OP_SW) ? S_SWWR : S_LWRD;
            S_LWRD:   if (memready) state_d = S_LWWR;
            S_SWWR:   if (memready) state_d = S_FETCH;
            S_RTYPEEX: begin
                if (funct_ok) begin
                    state_d  = S_RTYPEWR;
                    rt_alu_d = funct_alu;
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_ADDIEX: state_d = S_ADDIWR;
            S_LWWR, S_RTYPEWR, S_BEQEX, S_BNEEX, S_ADDIWR, S_JEX:
                state_d = S_FETCH;
            S_ILLEGAL: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
                state_d = S_ILLEGAL;
`else
                state_d = S_FETCH;
`endif
            end
            default: begin
                state_d = S_FETCH;
                k_d     = 2'd0;
            end
        endcase
    end

    // State registers
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            k_q      <= 2'd0;
            rt_alu_q <= ALU_ADD;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            rt_alu_q <= rt_alu_d;
        end
    end

    // Output decode. Everything is forced low while reset is high, which is
    // what makes a reset during a memory wait abandon the access at once.
    always_comb begin
        pcen       = 1'b0;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = '0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = 3'b000;
        instr_done = 1'b0;
        trap       = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    memread    = 1'b1;
                    alusrcb    = 2'b01;
                    alucontrol = ALU_ADD;
                    // IR chunk load and PC+1 happen only on the completing cycle
                    if (memready) begin
                        irwrite = CHUNKS'(1) << k_q;
                        pcen    = 1'b1;
                    end
                end
                S_DECODE: begin
                    alusrcb    = 2'b11;
                    alucontrol = ALU_ADD;
                end
                S_MEMADR, S_ADDIEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    alucontrol = ALU_ADD;
                end
                S_LWRD: begin
                    iord    = 1'b1;
                    memread = 1'b1;
                end
                S_LWWR: begin
                    regwrite   = 1'b1;
                    memtoreg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_SWWR: begin
                    iord       = 1'b1;
                    memwrite   = 1'b1;
                    instr_done = memready;
                end
                S_RTYPEEX: begin
                    alusrca    = 1'b1;
                    alucontrol = funct_alu;
                end
                S_RTYPEWR: begin
                    regdst     = 1'b1;
                    regwrite   = 1'b1;
                    alucontrol = rt_alu_q;
                    instr_done = 1'b1;
                end
                S_BEQEX, S_BNEEX: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = 2'b01;
                    pcen       = (state_q == S_BEQEX) ? zero : ~zero;
                    instr_done = 1'b1;
                end
                S_ADDIWR: begin
                    regwrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JEX: begin
                    pcsrc      = 2'b10;
                    pcen       = 1'b1;
                    instr_done = 1'b1;
                end
                S_ILLEGAL: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
                    trap = 1'b1;
`else
                    instr_done = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
//------------------------------------------------------------------------------
// tb_mips_mc_controller
//
// Self-checking bench for mips_mc_controller. Three instances (WIDTH 8, 16
// and 32) share clock and instruction fields; each has its own reset and
// memready. Only the instance under test sees memready; the others idle in
// FETCH. Expected control vectors are hand-written per state.
//------------------------------------------------------------------------------
module tb_mips_mc_controller;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] F_ADD   = 6'b100000;

    typedef struct packed {
        logic       pcen;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic [3:0] irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       instr_done;
        logic       trap;
    } ctl_t;

    typedef struct {
        string      name;
        int         sel;     // 0: WIDTH 8, 1: WIDTH 16, 2: WIDTH 32
        logic       mr;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        ctl_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst8, rst16, rst32;
    logic       mr8, mr16, mr32;
    logic [5:0] op, funct;
    logic       zero;

    ctl_t       o8, o16, o32;
    logic [1:0] irw16;
    logic [0:0] irw32;

    int checks   = 0;
    int failures = 0;

    logic mon16 = 1'b0;
    logic rw16_seen = 1'b0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    assign o16.irwrite = {2'b00, irw16};
    assign o32.irwrite = {3'b000, irw32};

    mips_mc_controller #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset(rst8), .op(op), .funct(funct), .zero(zero), .memready(mr8),
        .pcen(o8.pcen), .pcsrc(o8.pcsrc), .iord(o8.iord), .memread(o8.memread),
        .memwrite(o8.memwrite), .irwrite(o8.irwrite), .regdst(o8.regdst),
        .memtoreg(o8.memtoreg), .regwrite(o8.regwrite), .alusrca(o8.alusrca),
        .alusrcb(o8.alusrcb), .alucontrol(o8.alucontrol), .instr_done(o8.instr_done),
        .trap(o8.trap)
    );

    mips_mc_controller #(.WIDTH(16)) u_w16 (
        .clk(clk), .reset(rst16), .op(op), .funct(funct), .zero(zero), .memready(mr16),
        .pcen(o16.pcen), .pcsrc(o16.pcsrc), .iord(o16.iord), .memread(o16.memread),
        .memwrite(o16.memwrite), .irwrite(irw16), .regdst(o16.regdst),
        .memtoreg(o16.memtoreg), .regwrite(o16.regwrite), .alusrca(o16.alusrca),
        .alusrcb(o16.alusrcb), .alucontrol(o16.alucontrol), .instr_done(o16.instr_done),
        .trap(o16.trap)
    );

    mips_mc_controller #(.WIDTH(32)) u_w32 (
        .clk(clk), .reset(rst32), .op(op), .funct(funct), .zero(zero), .memready(mr32),
        .pcen(o32.pcen), .pcsrc(o32.pcsrc), .iord(o32.iord), .memread(o32.memread),
        .memwrite(o32.memwrite), .irwrite(irw32), .regdst(o32.regdst),
        .memtoreg(o32.memtoreg), .regwrite(o32.regwrite), .alusrca(o32.alusrca),
        .alusrcb(o32.alusrcb), .alucontrol(o32.alucontrol), .instr_done(o32.instr_done),
        .trap(o32.trap)
    );

    // Sticky record of any regwrite from the WIDTH=16 instance while watched
    always @(negedge clk) begin
        if (mon16 && o16.regwrite) rw16_seen = 1'b1;
    end

    // ---------------- expected vectors per state ----------------
    function automatic ctl_t f_fetch(logic [3:0] irw);
        ctl_t c = '0;
        c.memread = 1'b1; c.alusrcb = 2'b01; c.alucontrol = 3'b010;
        c.irwrite = irw; c.pcen = |irw;
        return c;
    endfunction
    function automatic ctl_t f_decode();
        ctl_t c = '0;
        c.alusrcb = 2'b11; c.alucontrol = 3'b010;
        return c;
    endfunction
    function automatic ctl_t f_memadr();   // also ADDIEX
        ctl_t c = '0;
        c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010;
        return c;
    endfunction
    function automatic ctl_t f_lwrd();
        ctl_t c = '0;
        c.iord = 1'b1; c.memread = 1'b1;
        return c;
    endfunction
    function automatic ctl_t f_lwwr();
        ctl_t c = '0;
        c.regwrite = 1'b1; c.memtoreg = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t f_swwr(logic done);
        ctl_t c = '0;
        c.iord = 1'b1; c.memwrite = 1'b1; c.instr_done = done;
        return c;
    endfunction
    function automatic ctl_t f_rtex(logic [2:0] alu);
        ctl_t c = '0;
        c.alusrca = 1'b1; c.alucontrol = alu;
        return c;
    endfunction
    function automatic ctl_t f_rtwr(logic [2:0] alu);
        ctl_t c = '0;
        c.regdst = 1'b1; c.regwrite = 1'b1; c.alucontrol = alu; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t f_br(logic pc);
        ctl_t c = '0;
        c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
        c.pcen = pc; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t f_addiwr();
        ctl_t c = '0;
        c.regwrite = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t f_jex();
        ctl_t c = '0;
        c.pcsrc = 2'b10; c.pcen = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t f_illegal();
        ctl_t c = '0;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        c.trap = 1'b1;
`else
        c.instr_done = 1'b1;
`endif
        return c;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add(string nm, int sel, logic mr, logic [5:0] o, logic [5:0] f,
                       logic z, ctl_t e);
        vec_t v;
        v.name = nm; v.sel = sel; v.mr = mr; v.op = o; v.funct = f; v.zero = z; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic add_fetch(string nm, int sel, int n, logic [5:0] o, logic [5:0] f,
                             logic z);
        for (int i = 0; i < n; i++) add(nm, sel, 1'b1, o, f, z, f_fetch(4'(1 << i)));
    endtask

    // Drive one cycle's inputs, compare before the next rising edge, advance.
    task automatic run_vec(vec_t v);
        ctl_t got;
        mr8   = (v.sel == 0) ? v.mr : 1'b0;
        mr16  = (v.sel == 1) ? v.mr : 1'b0;
        mr32  = (v.sel == 2) ? v.mr : 1'b0;
        op    = v.op;
        funct = v.funct;
        zero  = v.zero;
        #2;
        got = (v.sel == 0) ? o8 : (v.sel == 1) ? o16 : o32;
        check(v.name, 32'(got), 32'(v.exp));
        @(posedge clk);
        #1;
    endtask

    task automatic step(string nm, int sel, logic mr, logic [5:0] o, logic [5:0] f,
                        logic z, ctl_t e);
        vec_t v;
        v.name = nm; v.sel = sel; v.mr = mr; v.op = o; v.funct = f; v.zero = z; v.exp = e;
        run_vec(v);
    endtask

    initial begin
        logic [5:0] fn_tab[5];
        logic [2:0] alu_tab[5];
        fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        alu_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

        // ---- vector table ----
        // WIDTH=8 add: four fetch chunks, decode, execute, writeback (7 cycles)
        add_fetch("add8_fetch", 0, 4, OP_R, F_ADD, 1'b0);
        add("add8_decode", 0, 1'b1, OP_R, F_ADD, 1'b0, f_decode());
        add("add8_ex",     0, 1'b1, OP_R, F_ADD, 1'b0, f_rtex(3'b010));
        add("add8_wr",     0, 1'b1, OP_R, F_ADD, 1'b0, f_rtwr(3'b010));
        // WIDTH=32 R-type funct sweep
        for (int i = 0; i < 5; i++) begin
            add_fetch("rt32_fetch", 2, 1, OP_R, fn_tab[i], 1'b0);
            add("rt32_decode", 2, 1'b1, OP_R, fn_tab[i], 1'b0, f_decode());
            add("rt32_ex",     2, 1'b1, OP_R, fn_tab[i], 1'b0, f_rtex(alu_tab[i]));
            add("rt32_wr",     2, 1'b1, OP_R, fn_tab[i], 1'b0, f_rtwr(alu_tab[i]));
        end
        // WIDTH=16 LW with two wait cycles in LWRD (8 cycles total)
        add_fetch("lw16_fetch", 1, 2, OP_LW, 6'd0, 1'b0);
        add("lw16_decode", 1, 1'b1, OP_LW, 6'd0, 1'b0, f_decode());
        add("lw16_memadr", 1, 1'b1, OP_LW, 6'd0, 1'b0, f_memadr());
        add("lw16_rd_wait", 1, 1'b0, OP_LW, 6'd0, 1'b0, f_lwrd());
        add("lw16_rd_wait", 1, 1'b0, OP_LW, 6'd0, 1'b0, f_lwrd());
        add("lw16_rd_done", 1, 1'b1, OP_LW, 6'd0, 1'b0, f_lwrd());
        add("lw16_wr",      1, 1'b1, OP_LW, 6'd0, 1'b0, f_lwwr());
        // WIDTH=16 ADDI with a fetch wait state: no strobes while stalled
        add("addi16_fstall", 1, 1'b0, OP_ADDI, 6'd0, 1'b0, f_fetch(4'b0000));
        add_fetch("addi16_fetch", 1, 2, OP_ADDI, 6'd0, 1'b0);
        add("addi16_decode", 1, 1'b1, OP_ADDI, 6'd0, 1'b0, f_decode());
        add("addi16_ex",     1, 1'b1, OP_ADDI, 6'd0, 1'b0, f_memadr());
        add("addi16_wr",     1, 1'b1, OP_ADDI, 6'd0, 1'b0, f_addiwr());
        // WIDTH=8 BEQ taken then BNE not taken, both with zero=1
        add_fetch("beq8_fetch", 0, 4, OP_BEQ, 6'd0, 1'b1);
        add("beq8_decode", 0, 1'b1, OP_BEQ, 6'd0, 1'b1, f_decode());
        add("beq8_ex",     0, 1'b1, OP_BEQ, 6'd0, 1'b1, f_br(1'b1));
        add_fetch("bne8_fetch", 0, 4, OP_BNE, 6'd0, 1'b1);
        add("bne8_decode", 0, 1'b1, OP_BNE, 6'd0, 1'b1, f_decode());
        add("bne8_ex",     0, 1'b1, OP_BNE, 6'd0, 1'b1, f_br(1'b0));
        // WIDTH=32 BEQ/BNE with zero=0
        add_fetch("beq32_fetch", 2, 1, OP_BEQ, 6'd0, 1'b0);
        add("beq32_decode", 2, 1'b1, OP_BEQ, 6'd0, 1'b0, f_decode());
        add("beq32_ex",     2, 1'b1, OP_BEQ, 6'd0, 1'b0, f_br(1'b0));
        add_fetch("bne32_fetch", 2, 1, OP_BNE, 6'd0, 1'b0);
        add("bne32_decode", 2, 1'b1, OP_BNE, 6'd0, 1'b0, f_decode());
        add("bne32_ex",     2, 1'b1, OP_BNE, 6'd0, 1'b0, f_br(1'b1));
        // WIDTH=32 SW with three wait cycles in SWWR
        add_fetch("sw32_fetch", 2, 1, OP_SW, 6'd0, 1'b0);
        add("sw32_decode", 2, 1'b1, OP_SW, 6'd0, 1'b0, f_decode());
        add("sw32_memadr", 2, 1'b1, OP_SW, 6'd0, 1'b0, f_memadr());
        for (int i = 0; i < 3; i++)
            add("sw32_wr_wait", 2, 1'b0, OP_SW, 6'd0, 1'b0, f_swwr(1'b0));
        add("sw32_wr_done", 2, 1'b1, OP_SW, 6'd0, 1'b0, f_swwr(1'b1));
        // WIDTH=32 J
        add_fetch("j32_fetch", 2, 1, OP_J, 6'd0, 1'b0);
        add("j32_decode", 2, 1'b1, OP_J, 6'd0, 1'b0, f_decode());
        add("j32_ex",     2, 1'b1, OP_J, 6'd0, 1'b0, f_jex());
        // WIDTH=8 illegal opcode
        add_fetch("ill8_fetch", 0, 4, OP_BAD, 6'd0, 1'b0);
        add("ill8_decode", 0, 1'b1, OP_BAD, 6'd0, 1'b0, f_decode());
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 5; i++)
            add("ill8_trap", 0, 1'b1, OP_BAD, 6'd0, 1'b0, f_illegal());
`else
        add("ill8_nop",      0, 1'b1, OP_BAD, 6'd0, 1'b0, f_illegal());
        add("ill8_refetch",  0, 1'b1, OP_R,   F_ADD, 1'b0, f_fetch(4'b0001));
`endif

        // ---- reset ----
        rst8 = 1'b1; rst16 = 1'b1; rst32 = 1'b1;
        mr8 = 1'b0; mr16 = 1'b0; mr32 = 1'b0;
        op = OP_R; funct = F_ADD; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // memready high would strobe in FETCH; reset must still force all 0
        mr8 = 1'b1; mr16 = 1'b1; mr32 = 1'b1;
        #2;
        check("reset_w8",  32'(o8),  32'(ctl_t'('0)));
        check("reset_w16", 32'(o16), 32'(ctl_t'('0)));
        check("reset_w32", 32'(o32), 32'(ctl_t'('0)));
        mr8 = 1'b0; mr16 = 1'b0; mr32 = 1'b0;
        rst8 = 1'b0; rst16 = 1'b0; rst32 = 1'b0;
        @(posedge clk);
        #1;

        // ---- table ----
        foreach (tbl[i]) run_vec(tbl[i]);

        // ---- reset during an LWRD wait on WIDTH=16 ----
        mon16 = 1'b1;
        step("rlw16_fetch0", 1, 1'b1, OP_LW, 6'd0, 1'b0, f_fetch(4'b0001));
        step("rlw16_fetch1", 1, 1'b1, OP_LW, 6'd0, 1'b0, f_fetch(4'b0010));
        step("rlw16_decode", 1, 1'b1, OP_LW, 6'd0, 1'b0, f_decode());
        step("rlw16_memadr", 1, 1'b1, OP_LW, 6'd0, 1'b0, f_memadr());
        step("rlw16_rd_wait", 1, 1'b0, OP_LW, 6'd0, 1'b0, f_lwrd());
        rst16 = 1'b1;
        #2;
        check("rlw16_in_reset", 32'(o16), 32'(ctl_t'('0)));
        @(posedge clk);
        #1;
        rst16 = 1'b0;
        step("rlw16_refetch0", 1, 1'b1, OP_LW,  6'd0, 1'b0, f_fetch(4'b0001));
        step("rlw16_refetch1", 1, 1'b1, OP_BEQ, 6'd0, 1'b0, f_fetch(4'b0010));
        step("rlw16_decode2",  1, 1'b1, OP_BEQ, 6'd0, 1'b0, f_decode());
        step("rlw16_beq",      1, 1'b1, OP_BEQ, 6'd0, 1'b0, f_br(1'b0));
        mon16 = 1'b0;
        check("rlw16_no_regwrite", 32'(rw16_seen), 32'd0);

`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        // ---- only reset leaves TRAP ----
        rst8 = 1'b1;
        mr8  = 1'b1;
        #2;
        check("trap8_in_reset", 32'(o8), 32'(ctl_t'('0)));
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        step("trap8_exit_fetch", 0, 1'b1, OP_R, F_ADD, 1'b0, f_fetch(4'b0001));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
